// File: rtl/sbmips_lsu_pkg.sv
// rtl/sbmips_lsu_pkg.sv - op codes, FSM states and lane widths shared by the load/store unit
package sbmips_lsu_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Size/sign codes carried in opcode bits 2:0
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Stores have no unsigned variants; loads accept all five codes
  function automatic logic lsu_op_legal(input logic we, input logic [2:0] op);
    if (we) return (op == LSU_B) || (op == LSU_H) || (op == LSU_W);
    return (op == LSU_B) || (op == LSU_H) || (op == LSU_W) ||
           (op == LSU_BU) || (op == LSU_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and memory port A signals of the load/store unit
interface load_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_rdata;

  // The load/store unit itself
  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc,
    output mem_addr, mem_wdata, mem_en, mem_we
  );

  // The CPU and memory around it
  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
    input  mem_addr, mem_wdata, mem_en, mem_we
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads and byte/half merge for stores
module lsu_align
  import sbmips_lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]        sh;
  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;
  logic [31:0]       mask;
  logic [31:0]       ins;

  assign sh     = {off_i, 3'b000};
  assign lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Little-endian byte lane select
  always_comb begin
    lane_b = rdata_i[7:0];
    case (off_i)
      2'd1:    lane_b = rdata_i[15:8];
      2'd2:    lane_b = rdata_i[23:16];
      2'd3:    lane_b = rdata_i[31:24];
      default: lane_b = rdata_i[7:0];
    endcase
  end

  // Extend the selected lane for loads and build the store merge mask
  always_comb begin
    load_o = rdata_i;
    mask   = '1;
    ins    = wdata_i;
    case (op_i)
      LSU_B: begin
        load_o = {{(WORD_W-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
        mask   = 32'h0000_00ff << sh;
        ins    = {24'd0, wdata_i[7:0]} << sh;
      end
      LSU_BU: load_o = {{(WORD_W-BYTE_W){1'b0}}, lane_b};
      LSU_H: begin
        load_o = {{(WORD_W-HALF_W){lane_h[HALF_W-1]}}, lane_h};
        mask   = 32'h0000_ffff << sh;
        ins    = {16'd0, wdata_i[15:0]} << sh;
      end
      LSU_HU:  load_o = {{(WORD_W-HALF_W){1'b0}}, lane_h};
      default: ;
    endcase
    merge_o = (rdata_i & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS load/store FSM on memory port A; SBMIPS_LSU_ALIGN_EXC_EN traps misalignment
module load_store_unit
  import sbmips_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e  state_q;
  logic        we_q;
  logic        exc_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mwdata_q;

  logic [31:0] addr_d;
  logic        exc_d;
  logic        is_half;
  logic        is_word;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign is_half = (bus.req_op == LSU_H) || (bus.req_op == LSU_HU);
  assign is_word = (bus.req_op == LSU_W);

`ifdef SBMIPS_LSU_ALIGN_EXC_EN
  logic misalign;
  assign misalign = (is_half && bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] != 2'b00));
  assign addr_d   = bus.req_addr;
  assign exc_d    = !lsu_op_legal(bus.req_we, bus.req_op) || misalign;
`else
  // Misaligned addresses are silently rounded down to the access size
  assign addr_d = {bus.req_addr[31:2],
                   is_word ? 2'b00 : {bus.req_addr[1], bus.req_addr[0] & ~is_half}};
  assign exc_d  = !lsu_op_legal(bus.req_we, bus.req_op);
`endif

  lsu_align u_align (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .rdata_i (bus.mem_rdata),
    .wdata_i (wdata_q),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

  // Memory/response outputs decode directly from state so reset kills them at once
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_exc   = (state_q == ST_RESP) && exc_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_en     = (state_q == ST_ISSUE) || (state_q == ST_WRITE);
  assign bus.mem_we     = ((state_q == ST_ISSUE) && we_q && (op_q == LSU_W)) ||
                          (state_q == ST_WRITE);
  assign bus.mem_addr   = addr_q[31:2];
  assign bus.mem_wdata  = mwdata_q;

  // Request FSM: accept, issue, read-modify-write for sub-word stores, respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      exc_q    <= 1'b0;
      op_q     <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      mwdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            op_q    <= bus.req_op;
            addr_q  <= addr_d;
            wdata_q <= bus.req_wdata;
            exc_q   <= exc_d;
            rdata_q <= 32'd0;
            // sw drives its data straight out in ISSUE
            if (!exc_d && bus.req_we && is_word) mwdata_q <= bus.req_wdata;
            state_q <= exc_d ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_q) state_q <= (op_q == LSU_W) ? ST_RESP : ST_MERGE;
          else      state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          rdata_q <= load_data;
          state_q <= ST_RESP;
        end
        ST_MERGE: begin
          mwdata_q <= merge_data;
          state_q  <= ST_WRITE;
        end
        ST_WRITE: state_q <= ST_RESP;
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import sbmips_lsu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port A memory: registered read, write when en&we
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= mem[bus.mem_addr[5:0]];
      if (bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  // Reference memory image, updated by the model only
  logic [31:0] ref_mem [0:63];

  // Access monitor for the current request
  int          n_en;
  int          n_we;
  int          n_badaddr;
  logic [29:0] exp_waddr;
  always @(negedge clk) begin
    if (bus.mem_en) begin
      n_en++;
      if (bus.mem_we) n_we++;
      if (bus.mem_addr != exp_waddr) n_badaddr++;
    end
  end

  logic [31:0] last_rdata;
  logic        last_exc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: byte-addressed arithmetic on the reference image
  task automatic ref_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output logic exc, output logic [31:0] rd,
                         output int lat, output int en_cnt, output int we_cnt,
                         output logic [29:0] wa);
    int          size;
    int          off;
    logic        legal;
    logic        mis;
    logic [31:0] ea;
    logic [63:0] val;
    logic [63:0] msk;
    logic [31:0] w;
    legal = we ? (op == 3'd0 || op == 3'd1 || op == 3'd3)
               : (op == 3'd0 || op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd5);
    size  = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    mis   = (addr % size) != 0;
`ifdef SBMIPS_LSU_ALIGN_EXC_EN
    exc = !legal || mis;
    ea  = addr;
`else
    exc = !legal;
    ea  = addr - (addr % size);
`endif
    rd  = 32'd0;
    wa  = ea[31:2];
    off = int'(ea % 4);
    if (exc) begin
      lat = 1; en_cnt = 0; we_cnt = 0;
    end else if (!we) begin
      msk = (64'd1 << (8 * size)) - 64'd1;
      val = ({32'd0, ref_mem[ea[7:2]]} >> (8 * off)) & msk;
      if (op[2] == 1'b0 && size < 4 && val[8*size-1]) val = val | ~msk;
      rd  = val[31:0];
      lat = 3; en_cnt = 1; we_cnt = 0;
    end else begin
      w = ref_mem[ea[7:2]];
      for (int i = 0; i < size; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[ea[7:2]] = w;
      lat    = (size == 4) ? 2 : 4;
      en_cnt = (size == 4) ? 1 : 2;
      we_cnt = 1;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd);
    logic        e_exc;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_en;
    int          e_we;
    logic [29:0] e_wa;
    int          lat;
    ref_req(we, op, addr, wd, e_exc, e_rd, e_lat, e_en, e_we, e_wa);
    @(negedge clk);
    chk("req_ready", {31'd0, bus.req_ready}, 32'd1);
    n_en = 0; n_we = 0; n_badaddr = 0; exp_waddr = e_wa;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, e_lat);
    chk("resp_rdata", bus.resp_rdata, e_rd);
    chk("resp_exc", {31'd0, bus.resp_exc}, {31'd0, e_exc});
    chk("mem_en_cycles", n_en, e_en);
    chk("mem_we_cycles", n_we, e_we);
    chk("mem_addr_bad", n_badaddr, 0);
    last_rdata = bus.resp_rdata;
    last_exc   = bus.resp_exc;
  endtask

  initial begin
    logic [31:0] v;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    exp_waddr = 30'd0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[4] = 32'h80ff7f01;
    ref_mem[4] = 32'h80ff7f01;

    #12;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_addr", {2'd0, bus.mem_addr}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load extension on a known word
    do_req(1'b0, LSU_B, 32'h12, 32'd0);  chk("lb_0x12", last_rdata, 32'hffffffff);
    do_req(1'b0, LSU_BU, 32'h13, 32'd0); chk("lbu_0x13", last_rdata, 32'h00000080);
    do_req(1'b0, LSU_H, 32'h12, 32'd0);  chk("lh_0x12", last_rdata, 32'hffff80ff);
    do_req(1'b0, LSU_W, 32'h10, 32'd0);  chk("lw_0x10", last_rdata, 32'h80ff7f01);

    // Word store, then sub-word read-modify-write
    do_req(1'b1, LSU_W, 32'h20, 32'hdeadbeef);
    do_req(1'b0, LSU_W, 32'h20, 32'd0);  chk("lw_after_sw", last_rdata, 32'hdeadbeef);
    do_req(1'b1, LSU_B, 32'h21, 32'h55);
    do_req(1'b0, LSU_W, 32'h20, 32'd0);  chk("lw_after_sb", last_rdata, 32'hdead55ef);
    do_req(1'b1, LSU_H, 32'h22, 32'h1234);
    do_req(1'b0, LSU_W, 32'h20, 32'd0);  chk("lw_after_sh", last_rdata, 32'h123455ef);

    // Misaligned word load
    do_req(1'b0, LSU_W, 32'h11, 32'd0);
`ifdef SBMIPS_LSU_ALIGN_EXC_EN
    chk("lw_mis_exc", {31'd0, last_exc}, 32'd1);
`else
    chk("lw_mis_exc", {31'd0, last_exc}, 32'd0);
    chk("lw_mis_data", last_rdata, 32'h80ff7f01);
`endif

    // Illegal combinations
    do_req(1'b1, LSU_BU, 32'h20, 32'h77); chk("sbu_exc", {31'd0, last_exc}, 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'd0);  chk("op010_exc", {31'd0, last_exc}, 32'd1);

    // Reset in the WRITE cycle of an sb must commit nothing
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_op = LSU_B; bus.req_addr = 32'h21; bus.req_wdata = 32'haa;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstw_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rstw_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rstw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstw_mem_addr", {2'd0, bus.mem_addr}, 32'd0);
    chk("rstw_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
    do_req(1'b0, LSU_W, 32'h20, 32'd0);  chk("lw_after_rst", last_rdata, 32'h123455ef);

    // Random traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
